// File: rtl/mv_pkg.sv
// Shared types for the 4x4 FP32 matrix-vector issue path.
package mv_pkg;
   typedef logic [3:0][31:0]  vec4_t;   // [3] = x ... [0] = w
   typedef logic [15:0][31:0] mat4_t;   // [15] = m00 ... [0] = m33

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } mv_iss_state_t;

   localparam int unsigned CNT_W = 8;
endpackage

// File: rtl/mv_credit_cnt.sv
// Credit counter mirroring free slots in the downstream result FIFO.
module mv_credit_cnt
   import mv_pkg::*;
#(
   parameter int unsigned CREDITS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             take,
   input  logic             ret,
   output logic [CNT_W-1:0] count,
   output logic             has_credit,
   output logic             full,
   output logic             err
);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(CREDITS);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_s;
   logic             err_r;
   logic             err_s;

   // Next count: a simultaneous take and return cancel out; a return at full is dropped and flagged
   always_comb begin
      count_s = count_r;
      err_s   = err_r;
      if (take && !ret) begin
         count_s = count_r - ONE_C;
      end else if (ret && !take) begin
         if (count_r == MAX_C) begin
            err_s = 1'b1;
         end else begin
            count_s = count_r + ONE_C;
         end
      end else begin
         count_s = count_r;
      end
   end

   // Count and sticky error registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= MAX_C;
         err_r   <= 1'b0;
      end else begin
         count_r <= count_s;
         err_r   <= err_s;
      end
   end

   assign count      = count_r;
   assign has_credit = (count_r != {CNT_W{1'b0}});
   assign full       = (count_r == MAX_C);
   assign err        = err_r;
endmodule

// File: rtl/mv_issue_4x4_fp32.sv
// Issue controller: loads one matrix, then meters a vertex batch into the
// multiplier against result-FIFO credits and reports when the batch has drained.
module mv_issue_4x4_fp32
   import mv_pkg::*;
#(
   parameter int unsigned IDW     = 8,
   parameter int unsigned CREDITS = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           mat_valid,
   output logic           mat_ready,
   input  logic [511:0]   mat_data,
   input  logic           v_valid,
   output logic           v_ready,
   input  logic           v_last,
   input  logic [127:0]   v_data,
   output logic           m_valid,
   output logic [511:0]   m_data,
   output logic           in_valid,
   output logic [IDW-1:0] in_vertex_id,
   output logic [31:0]    vx,
   output logic [31:0]    vy,
   output logic [31:0]    vz,
   output logic [31:0]    vw,
   input  logic           credit_ret,
   output logic           busy,
   output logic           batch_done,
   output logic           credit_err
);
   localparam logic [IDW-1:0] ID_ONE = IDW'(1);

   mv_iss_state_t    state_r;
   mv_iss_state_t    state_s;
   logic [IDW-1:0]   id_r;
   logic [IDW-1:0]   in_id_r;
   logic             m_valid_r;
   mat4_t            m_data_r;
   logic             in_valid_r;
   vec4_t            v_r;
   logic             batch_done_r;
   logic             mat_hs_s;
   logic             v_hs_s;
   logic             has_credit_s;
   logic             full_s;
   logic             err_s;
   logic [CNT_W-1:0] credit_level_unused_s;

   // Ready depends only on state and credits, so upstream never sees a valid->ready path
   assign mat_ready = !rst && (state_r == IDLE);
   assign v_ready   = !rst && (state_r == RUN) && has_credit_s;
   assign mat_hs_s  = mat_valid && mat_ready;
   assign v_hs_s    = v_valid && v_ready;

   mv_credit_cnt #(.CREDITS(CREDITS)) u_credit (
      .clk        (clk),
      .rst        (rst),
      .take       (v_hs_s),
      .ret        (credit_ret),
      .count      (credit_level_unused_s),
      .has_credit (has_credit_s),
      .full       (full_s),
      .err        (err_s)
   );

   // Batch sequencing: matrix load, vertex issue until v_last, wait for all credits back
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (mat_hs_s) state_s = RUN;
            else          state_s = IDLE;
         end
         RUN: begin
            if (v_hs_s && v_last) state_s = DRAIN;
            else                  state_s = RUN;
         end
         DRAIN: begin
            if (full_s) state_s = IDLE;
            else        state_s = DRAIN;
         end
         default: state_s = IDLE;
      endcase
   end

   // State, ID counter and all registered multiplier-facing outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         id_r         <= '0;
         in_id_r      <= '0;
         m_valid_r    <= 1'b0;
         m_data_r     <= '0;
         in_valid_r   <= 1'b0;
         v_r          <= '0;
         batch_done_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         m_valid_r    <= mat_hs_s;
         in_valid_r   <= v_hs_s;
         batch_done_r <= (state_r == DRAIN) && full_s;
         if (mat_hs_s) begin
            m_data_r <= mat_data;
            id_r     <= '0;
         end else if (v_hs_s) begin
            v_r     <= v_data;
            in_id_r <= id_r;
            id_r    <= id_r + ID_ONE;
         end
      end
   end

   assign m_valid      = m_valid_r;
   assign m_data       = m_data_r;
   assign in_valid     = in_valid_r;
   assign in_vertex_id = in_id_r;
   assign vx           = v_r[3];
   assign vy           = v_r[2];
   assign vz           = v_r[1];
   assign vw           = v_r[0];
   assign busy         = (state_r != IDLE);
   assign batch_done   = batch_done_r;
   assign credit_err   = err_s;
endmodule

// File: tb/tb_mv_issue_4x4_fp32.sv
// Scoreboard bench for mv_issue_4x4_fp32 (IDW=2, CREDITS=4).
module tb_mv_issue_4x4_fp32;
   localparam int IDW     = 2;
   localparam int CREDITS = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           mat_valid, mat_ready, v_valid, v_ready, v_last;
   logic [511:0]   mat_data, m_data;
   logic [127:0]   v_data;
   logic           m_valid, in_valid, credit_ret, busy, batch_done, credit_err;
   logic [IDW-1:0] in_vertex_id;
   logic [31:0]    vx, vy, vz, vw;

   int n_checks = 0;
   int n_fail   = 0;
   logic [IDW+127:0] exp_v[$];
   logic [511:0]     exp_m[$];
   logic [IDW+127:0] ev;
   logic [511:0]     em;
   logic [IDW-1:0]   id_m;

   localparam logic [511:0] MI = {
      32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
      32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000,
      32'h0000_0000, 32'h0000_0000, 32'h3F80_0000, 32'h0000_0000,
      32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h3F80_0000};
   localparam logic [511:0] M2 = {16{32'hC0A0_0000}};
   localparam logic [511:0] M3 = {8{64'h1234_5678_9ABC_DEF0}};
   localparam logic [511:0] M4 = {16{32'h7F7F_FFFF}};
   localparam logic [511:0] M5 = {4{128'hFFFF_FFFF_0000_0001_8000_0000_7F80_0000}};

   always #5 clk = ~clk;

   mv_issue_4x4_fp32 #(.IDW(IDW), .CREDITS(CREDITS)) dut (
      .clk(clk), .rst(rst),
      .mat_valid(mat_valid), .mat_ready(mat_ready), .mat_data(mat_data),
      .v_valid(v_valid), .v_ready(v_ready), .v_last(v_last), .v_data(v_data),
      .m_valid(m_valid), .m_data(m_data),
      .in_valid(in_valid), .in_vertex_id(in_vertex_id),
      .vx(vx), .vy(vy), .vz(vz), .vw(vw),
      .credit_ret(credit_ret), .busy(busy), .batch_done(batch_done),
      .credit_err(credit_err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkw(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic load_mat(input logic [511:0] m);
      mat_valid = 1'b1;
      mat_data  = m;
      chk1("mat_ready_idle", mat_ready, 1'b1);
      exp_m.push_back(m);
      id_m = '0;
      tick;
      mat_valid = 1'b0;
      chk1("busy_run", busy, 1'b1);
      chk1("mat_ready_run", mat_ready, 1'b0);
   endtask

   // Offer a vertex for one cycle; hs says whether it must be accepted
   task automatic vtx(input logic [127:0] d, input logic last, input logic hs);
      v_valid = 1'b1;
      v_data  = d;
      v_last  = last;
      chk1("v_ready", v_ready, hs);
      if (hs) begin
         exp_v.push_back({id_m, d});
         id_m = id_m + 2'd1;
      end
      tick;
   endtask

   task automatic rets(input int n);
      credit_ret = 1'b1;
      repeat (n) tick;
      credit_ret = 1'b0;
   endtask

   // Credits are full while still in DRAIN; completion appears one cycle later
   task automatic finish_batch;
      chk1("batch_done_early", batch_done, 1'b0);
      tick;
      chk1("batch_done_pulse", batch_done, 1'b1);
      chk1("busy_done", busy, 1'b0);
      chk1("mat_ready_done", mat_ready, 1'b1);
      tick;
      chk1("batch_done_single", batch_done, 1'b0);
   endtask

   // Monitor: pop and compare every issued vertex and matrix load
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (in_valid !== 1'b0) begin
            n_checks++;
            if (exp_v.size() == 0) begin
               n_fail++;
               $display("FAIL vertex_unexpected: got id %0d data %h%h%h%h expected none",
                        in_vertex_id, vx, vy, vz, vw);
            end else begin
               ev = exp_v.pop_front();
               if ({in_vertex_id, vx, vy, vz, vw} !== ev) begin
                  n_fail++;
                  $display("FAIL vertex: got id %0d data %h%h%h%h expected id %0d data %h",
                           in_vertex_id, vx, vy, vz, vw, ev[IDW+127:128], ev[127:0]);
               end
            end
         end
         if (m_valid !== 1'b0) begin
            n_checks++;
            if (exp_m.size() == 0) begin
               n_fail++;
               $display("FAIL matrix_unexpected: got %h expected none", m_data);
            end else begin
               em = exp_m.pop_front();
               if (m_data !== em) begin
                  n_fail++;
                  $display("FAIL matrix: got %h expected %h", m_data, em);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; mat_valid = 1'b0; mat_data = '0; v_valid = 1'b0;
      v_last = 1'b0; v_data = '0; credit_ret = 1'b0; id_m = '0;
      tick;
      chk1("rst_mat_ready", mat_ready, 1'b0);
      chk1("rst_v_ready", v_ready, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chkw("rst_outputs", {m_data[383:0], in_vertex_id, vx, vy, vz, vw, m_valid, in_valid,
                           batch_done, credit_err}, '0);
      rst = 1'b0;
      #1;
      chk1("idle_mat_ready", mat_ready, 1'b1);
      chk1("idle_v_ready", v_ready, 1'b0);

      // Basic batch: identity matrix, 3 back-to-back vertices, 3 credits back
      load_mat(MI);
      vtx(128'h3F80_0000_4000_0000_4040_0000_4080_0000, 1'b0, 1'b1);
      vtx(128'hBF80_0000_0000_0000_7F80_0000_FFC0_0001, 1'b0, 1'b1);
      vtx(128'h0000_0001_8000_0000_4120_0000_C2C8_0000, 1'b1, 1'b1);
      v_valid = 1'b0; v_last = 1'b0;
      chk1("drain_v_ready", v_ready, 1'b0);
      chk1("drain_busy", busy, 1'b1);
      rets(3);
      finish_batch();

      // Backpressure: 4 credits then stall; one return allows exactly one more
      load_mat(M2);
      vtx(128'h1111_1111_2222_2222_3333_3333_4444_4444, 1'b0, 1'b1);
      vtx(128'h5555_5555_6666_6666_7777_7777_8888_8888, 1'b0, 1'b1);
      vtx(128'h9999_9999_AAAA_AAAA_BBBB_BBBB_CCCC_CCCC, 1'b0, 1'b1);
      vtx(128'hDDDD_DDDD_EEEE_EEEE_FFFF_FFFF_0000_0000, 1'b0, 1'b1);
      vtx(128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10, 1'b0, 1'b0);
      vtx(128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10, 1'b0, 1'b0);
      credit_ret = 1'b1;
      vtx(128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10, 1'b0, 1'b0);
      credit_ret = 1'b0;
      vtx(128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10, 1'b1, 1'b1);
      vtx(128'hA5A5_A5A5_5A5A_5A5A_A5A5_A5A5_5A5A_5A5A, 1'b1, 1'b0);
      v_valid = 1'b0; v_last = 1'b0;

      // Matrix offered during DRAIN waits for the batch_done cycle
      mat_valid = 1'b1; mat_data = M3;
      chk1("mat_ready_drain", mat_ready, 1'b0);
      rets(4);
      chk1("mat_ready_drain_full", mat_ready, 1'b0);
      chkw("m_data_hold", m_data, M2);
      tick;
      chk1("batch_done_mat", batch_done, 1'b1);
      chk1("mat_ready_batch_done", mat_ready, 1'b1);
      exp_m.push_back(M3);
      id_m = '0;
      tick;
      mat_valid = 1'b0;
      chk1("busy_m3", busy, 1'b1);
      chk1("batch_done_m3", batch_done, 1'b0);

      // Simultaneous issue and return at credits=1; IDs wrap 3->0
      vtx(128'h4000_0000_4000_0000_4000_0000_4000_0000, 1'b0, 1'b1);
      vtx(128'h4040_0000_4040_0000_4040_0000_4040_0000, 1'b0, 1'b1);
      vtx(128'h4080_0000_4080_0000_4080_0000_4080_0000, 1'b0, 1'b1);
      credit_ret = 1'b1;
      vtx(128'h40A0_0000_40A0_0000_40A0_0000_40A0_0000, 1'b0, 1'b1);
      credit_ret = 1'b0;
      chk1("v_ready_simul", v_ready, 1'b1);
      vtx(128'h40C0_0000_40C0_0000_40C0_0000_40C0_0000, 1'b0, 1'b1);
      v_valid = 1'b0;
      chk1("v_ready_zero", v_ready, 1'b0);
      rets(1);
      vtx(128'h40E0_0000_40E0_0000_40E0_0000_40E0_0000, 1'b1, 1'b1);
      v_valid = 1'b0; v_last = 1'b0;
      rets(4);
      finish_batch();

      // Return at full count is ignored and flags a sticky error
      chk1("credit_err_clear", credit_err, 1'b0);
      rets(1);
      chk1("credit_err_set", credit_err, 1'b1);
      tick; tick;
      chk1("credit_err_sticky", credit_err, 1'b1);

      // ID wrap with a return every cycle: IDs 0,1,2,3,0,1
      load_mat(M4);
      vtx(128'h0000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1);
      credit_ret = 1'b1;
      vtx(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
      vtx(128'h7F80_0001_FF80_0001_0000_0001_8000_0001, 1'b0, 1'b1);
      vtx(128'h1357_9BDF_2468_ACE0_0F0F_0F0F_F0F0_F0F0, 1'b0, 1'b1);
      vtx(128'hDEAD_BEEF_CAFE_BABE_FEED_FACE_0BAD_F00D, 1'b0, 1'b1);
      vtx(128'h3F00_0000_BF00_0000_3E80_0000_BE80_0000, 1'b1, 1'b1);
      credit_ret = 1'b0;
      v_valid = 1'b0; v_last = 1'b0;
      rets(1);
      finish_batch();

      // Asynchronous reset mid-RUN after two issues
      load_mat(M5);
      vtx(128'h1234_0000_5678_0000_9ABC_0000_DEF0_0000, 1'b0, 1'b1);
      vtx(128'h0000_1234_0000_5678_0000_9ABC_0000_DEF0, 1'b0, 1'b1);
      v_valid = 1'b0;
      tick;
      #2;
      rst = 1'b1;
      #1;
      chkw("rst_async_m_data", m_data, '0);
      chkw("rst_async_vertex", {in_vertex_id, vx, vy, vz, vw}, '0);
      chk1("rst_async_busy", busy, 1'b0);
      chk1("rst_async_err", credit_err, 1'b0);
      chk1("rst_async_mat_ready", mat_ready, 1'b0);
      chk1("rst_async_v_ready", v_ready, 1'b0);
      chk1("rst_async_pulses", m_valid | in_valid | batch_done, 1'b0);
      tick;
      rst = 1'b0;
      #1;
      chk1("post_rst_mat_ready", mat_ready, 1'b1);
      chk1("post_rst_v_ready", v_ready, 1'b0);

      // Fresh batch after reset: exactly CREDITS issues available
      load_mat(MI);
      vtx(128'h4110_0000_4120_0000_4130_0000_4140_0000, 1'b0, 1'b1);
      vtx(128'h4150_0000_4160_0000_4170_0000_4180_0000, 1'b0, 1'b1);
      vtx(128'h4188_0000_4190_0000_4198_0000_41A0_0000, 1'b0, 1'b1);
      vtx(128'h41A8_0000_41B0_0000_41B8_0000_41C0_0000, 1'b0, 1'b1);
      vtx(128'h41C8_0000_41D0_0000_41D8_0000_41E0_0000, 1'b0, 1'b0);
      rets(1);
      vtx(128'h41C8_0000_41D0_0000_41D8_0000_41E0_0000, 1'b1, 1'b1);
      v_valid = 1'b0; v_last = 1'b0;
      rets(4);
      finish_batch();

      tick; tick;
      chk1("vertex_queue_empty", exp_v.size() == 0, 1'b1);
      chk1("matrix_queue_empty", exp_m.size() == 0, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end
endmodule
